fma_bypass_ctrl: RTL

FMA_BYPASS_CTRL -- requirements
Module: fma_bypass_ctrl

---
 rtl/fma_bypass_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fma_bypass_ctrl.sv
// fma_bypass_ctrl: operand bypass and interlock control for a fixed-latency FMA pipeline.
// Define FMA_BYPASS_EN to forward in-flight results; without it any in-flight hit interlocks.
module fma_bypass_ctrl #(
    parameter int WIDTH     = 64,
    parameter int NSRC      = 3,
    parameter int DEPTH     = 4,
    parameter int RES_STAGE = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_wen,
    input  logic [4:0]              issue_rd,
    input  logic [NSRC*5-1:0]       src_addr,
    input  logic [NSRC*WIDTH-1:0]   rf_data,
    input  logic                    res_valid,
    input  logic [WIDTH-1:0]        res_data,
    output logic                    op_valid,
    output logic [NSRC*WIDTH-1:0]   op_data,
    output logic [NSRC-1:0]         op_bypassed,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [WIDTH-1:0]        wb_data
);
    logic             vld_q [DEPTH];
    logic             wen_q [DEPTH];
    logic [4:0]       rd_q  [DEPTH];
    logic             rdy_q [DEPTH];
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic                  fire;
    logic                  res_take;
    logic                  hit;
    logic                  fwd_ok;
    logic [WIDTH-1:0]      fwd_data;
    logic [NSRC-1:0]       stall_d;
    logic [NSRC-1:0]       byp_d;
    logic [NSRC*WIDTH-1:0] opd_d;
    logic                  op_valid_q;
    logic [NSRC-1:0]       op_byp_q;
    logic [NSRC*WIDTH-1:0] op_data_q;

    // a result only lands on a live writer; bubbles and non-writers ignore it
    assign res_take    = res_valid && vld_q[RES_STAGE] && wen_q[RES_STAGE];
    assign issue_ready = ~|stall_d;
    assign fire        = issue_valid && issue_ready;

    // per operand: find the youngest in-flight writer, then forward it or interlock
    always_comb begin
        stall_d  = '0;
        byp_d    = '0;
        opd_d    = rf_data;
        hit      = 1'b0;
        fwd_ok   = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit      = 1'b0;
            fwd_ok   = 1'b0;
            fwd_data = '0;
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (vld_q[j] && wen_q[j] && rd_q[j] == src_addr[i*5 +: 5]) begin
                    hit = 1'b1;
`ifdef FMA_BYPASS_EN
                    fwd_ok   = rdy_q[j] || (j == RES_STAGE && res_valid);
                    fwd_data = (j == RES_STAGE && res_valid) ? res_data : dat_q[j];
`endif
                end
            end
`ifdef FMA_BYPASS_EN
            stall_d[i] = hit && !fwd_ok;
            byp_d[i]   = hit && fwd_ok;
            if (hit && fwd_ok)
                opd_d[i*WIDTH +: WIDTH] = fwd_data;
`else
            stall_d[i] = hit;
`endif
        end
    end

    // in-flight tracker: shifts every cycle, result captured as the RES_STAGE entry moves on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k] <= 1'b0;
                wen_q[k] <= 1'b0;
                rd_q[k]  <= '0;
                rdy_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= fire;
            wen_q[0] <= fire && issue_wen;
            rd_q[0]  <= fire ? issue_rd : 5'd0;
            rdy_q[0] <= 1'b0;
            dat_q[0] <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                wen_q[k] <= wen_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                rdy_q[k] <= rdy_q[k-1] || (k - 1 == RES_STAGE && res_take);
                dat_q[k] <= (k - 1 == RES_STAGE && res_take) ? res_data : dat_q[k-1];
            end
        end
    end

    // operand register: captured on fire, held otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_valid_q <= 1'b0;
            op_byp_q   <= '0;
            op_data_q  <= '0;
        end else begin
            op_valid_q <= fire;
            if (fire) begin
                op_byp_q  <= byp_d;
                op_data_q <= opd_d;
            end
        end
    end

    assign op_valid    = op_valid_q;
    assign op_bypassed = op_byp_q;
    assign op_data     = op_data_q;
    assign wb_valid    = vld_q[DEPTH-1] && wen_q[DEPTH-1];
    assign wb_rd       = wb_valid ? rd_q[DEPTH-1] : 5'd0;
    assign wb_data     = wb_valid ? dat_q[DEPTH-1] : '0;
endmodule
